// File: rtl/apb_si_pkg.sv
// Shared types and constants for the APB slave-interface router.
package apb_si_pkg;

  // Routing target. The encoding of S0..S2 matches the slave index field.
  typedef enum logic [1:0] {
    TGT_S0   = 2'd0,
    TGT_S1   = 2'd1,
    TGT_S2   = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Read data returned for unmapped or disabled accesses.
  localparam logic [31:0] SI_DEFAULT_RDATA = 32'h0;

endpackage

// File: rtl/apb_si_clkgate.sv
// Latch-based clock gate: the enable is sampled while clk is low, so the
// gated clock never shows a partial high pulse.
module apb_si_clkgate (
  input  logic clk,
  input  logic rst_b,
  input  logic en_in,
  output logic pclk
);

  logic en;

  // Transparent while clk is low; cleared asynchronously by reset.
  always_latch begin
    if (!rst_b)
      en <= 1'b0;
    else if (!clk)
      en <= en_in;
  end

  assign pclk = clk & en;

endmodule

// File: rtl/apb_si.sv
// APB slave-interface router: one master port to three slaves.
// Optional build macro SI_PSLVERR_EN adds the pslverr_s error output.
module apb_si
  import apb_si_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEC_MSB = 15,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = DATA_W'(SI_DEFAULT_RDATA)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [2:0]        way_en,
  input  logic [DATA_W-1:0] pwdata_mi,
  input  logic [ADDR_W-1:0] paddr_mi,
  input  logic              pwrite_mi,
  input  logic              psel_arb,
  input  logic              penable_arb,
  input  logic [DATA_W-1:0] prdata_s0,
  input  logic [DATA_W-1:0] prdata_s1,
  input  logic [DATA_W-1:0] prdata_s2,
  input  logic              pready_s0,
  input  logic              pready_s1,
  input  logic              pready_s2,
  output logic              pclk_s0,
  output logic              pclk_s1,
  output logic              pclk_s2,
  output logic              psel_s0,
  output logic              psel_s1,
  output logic              psel_s2,
  output logic              penable_s0,
  output logic              penable_s1,
  output logic              penable_s2,
  output logic              pwrite_s,
  output logic [DATA_W-1:0] pwdata_s,
  output logic [ADDR_W-1:0] paddr_s,
  output logic [DATA_W-1:0] prdata_s,
`ifdef SI_PSLVERR_EN
  output logic              pslverr_s,
`endif
  output logic              pready_s
);

  state_e     state, state_nx;
  tgt_e       sel_q, sel_nx, dec_tgt, tgt;
  logic [1:0] idx;
  logic       xfer, enab;
  logic [2:0] pready_v, psel_v, pclk_v;

  assign idx      = paddr_mi[DEC_MSB -: 2];
  assign pready_v = {pready_s2, pready_s1, pready_s0};

  // Live address decode gated by the per-slave enable mask.
  always_comb begin
    dec_tgt = TGT_NONE;
    case (idx)
      2'd0:    if (way_en[0]) dec_tgt = TGT_S0;
      2'd1:    if (way_en[1]) dec_tgt = TGT_S1;
      2'd2:    if (way_en[2]) dec_tgt = TGT_S2;
      default: dec_tgt = TGT_NONE;
    endcase
  end

  // State and captured target registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      sel_q <= TGT_NONE;
    end else begin
      state <= state_nx;
      sel_q <= sel_nx;
    end
  end

  // Next state: latch the target at setup, release on done or deselect.
  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    case (state)
      ST_IDLE: begin
        if (psel_arb) begin
          state_nx = ST_ACCESS;
          sel_nx   = dec_tgt;
        end
      end
      ST_ACCESS: begin
        if (!psel_arb || (penable_arb && pready_s))
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Target is frozen once the access has started.
  assign tgt  = (state == ST_ACCESS) ? sel_q : dec_tgt;
  // Reset gates every select path so nothing leaks out while held in reset.
  assign xfer = rst_b & psel_arb;
  assign enab = xfer & penable_arb;

  assign psel_v[0] = xfer & (tgt == TGT_S0);
  assign psel_v[1] = xfer & (tgt == TGT_S1);
  assign psel_v[2] = xfer & (tgt == TGT_S2);

  assign psel_s0    = psel_v[0];
  assign psel_s1    = psel_v[1];
  assign psel_s2    = psel_v[2];
  assign penable_s0 = psel_v[0] & penable_arb;
  assign penable_s1 = psel_v[1] & penable_arb;
  assign penable_s2 = psel_v[2] & penable_arb;

  assign pwrite_s = pwrite_mi;
  assign paddr_s  = paddr_mi;
  assign pwdata_s = pwdata_mi;

  // Return path mux; unmapped targets complete with zero wait states.
  always_comb begin
    pready_s = 1'b0;
    prdata_s = '0;
    if (xfer) begin
      case (tgt)
        TGT_S0: begin
          prdata_s = prdata_s0;
          pready_s = pready_s0 & penable_arb;
        end
        TGT_S1: begin
          prdata_s = prdata_s1;
          pready_s = pready_s1 & penable_arb;
        end
        TGT_S2: begin
          prdata_s = prdata_s2;
          pready_s = pready_s2 & penable_arb;
        end
        default: begin
          if (penable_arb) begin
            pready_s = 1'b1;
            prdata_s = DEFAULT_RDATA;
          end
        end
      endcase
    end
  end

`ifdef SI_PSLVERR_EN
  logic [2:0] pready_q;

  // Previous slave ready, used to spot a ready edge outside an enable phase.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      pready_q <= '0;
    else
      pready_q <= pready_v;
  end

  assign pslverr_s = rst_b & ((enab & (tgt == TGT_NONE)) |
                              ((|(pready_v & ~pready_q)) & ~penable_arb));
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, pready_v, enab};
`endif

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_cg
      apb_si_clkgate u_cg (
        .clk   (clk),
        .rst_b (rst_b),
        .en_in (way_en[g]),
        .pclk  (pclk_v[g])
      );
    end
  endgenerate

  assign pclk_s0 = pclk_v[0];
  assign pclk_s1 = pclk_v[1];
  assign pclk_s2 = pclk_v[2];

endmodule

// File: tb/tb_apb_si.sv
// Self-checking bench for apb_si with a scoreboard of expected transfers.
module tb_apb_si;
  import apb_si_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [2:0]  way_en;
  logic [31:0] pwdata_mi;
  logic [15:0] paddr_mi;
  logic        pwrite_mi, psel_arb, penable_arb;
  logic [31:0] prdata_s0, prdata_s1, prdata_s2;
  logic        pready_s0, pready_s1, pready_s2;
  logic        pclk_s0, pclk_s1, pclk_s2;
  logic        psel_s0, psel_s1, psel_s2;
  logic        penable_s0, penable_s1, penable_s2;
  logic        pwrite_s, pready_s;
  logic [31:0] pwdata_s, prdata_s;
  logic [15:0] paddr_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  apb_si dut (
    .clk(clk), .rst_b(rst_b), .way_en(way_en), .pwdata_mi(pwdata_mi),
    .paddr_mi(paddr_mi), .pwrite_mi(pwrite_mi), .psel_arb(psel_arb),
    .penable_arb(penable_arb), .prdata_s0(prdata_s0), .prdata_s1(prdata_s1),
    .prdata_s2(prdata_s2), .pready_s0(pready_s0), .pready_s1(pready_s1),
    .pready_s2(pready_s2), .pclk_s0(pclk_s0), .pclk_s1(pclk_s1),
    .pclk_s2(pclk_s2), .psel_s0(psel_s0), .psel_s1(psel_s1), .psel_s2(psel_s2),
    .penable_s0(penable_s0), .penable_s1(penable_s1), .penable_s2(penable_s2),
    .pwrite_s(pwrite_s), .pwdata_s(pwdata_s), .paddr_s(paddr_s),
    .prdata_s(prdata_s), .pready_s(pready_s)
  );

  wire [2:0] psel_v = {psel_s2, psel_s1, psel_s0};
  wire [2:0] pen_v  = {penable_s2, penable_s1, penable_s0};
  wire [2:0] pclk_v = {pclk_s2, pclk_s1, pclk_s0};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_ready(input logic [2:0] r);
    {pready_s2, pready_s1, pready_s0} = r;
  endtask

  // One APB transfer: setup, wt wait states, then enable with ready.
  // chg moves paddr/way_en to another slave during the wait states.
  task automatic xfer(input logic [15:0] addr, input logic wr, input logic [2:0] way,
                      input logic [31:0] rdv, input int wt, input bit chg);
    logic [1:0]  ix;
    logic        hit;
    logic [2:0]  onehot;
    exp_t        e, got;
    ix     = addr[15:14];
    hit    = (ix != 2'd3) && way[ix];
    onehot = hit ? (3'b001 << ix) : 3'b000;
    e.sel   = onehot;
    e.rdata = hit ? rdv : 32'h0;
    sb.push_back(e);

    @(negedge clk);
    way_en = way; paddr_mi = addr; pwrite_mi = wr; pwdata_mi = $urandom;
    psel_arb = 1'b1; penable_arb = 1'b0; set_ready(3'b000);
    prdata_s0 = (ix == 2'd0) ? rdv : ~rdv;
    prdata_s1 = (ix == 2'd1) ? rdv : ~rdv;
    prdata_s2 = (ix == 2'd2) ? rdv : ~rdv;
    #2;
    chk("setup_psel", psel_v, onehot);
    chk("setup_pen", pen_v, 3'b000);
    chk("setup_rdy", pready_s, 1'b0);
    chk("bc_addr", paddr_s, addr);
    chk("bc_wdata", {pwrite_s, pwdata_s}, {wr, pwdata_mi});

    @(negedge clk);
    penable_arb = 1'b1;
    if (hit) begin
      for (int i = 0; i < wt; i++) begin
        if (chg && i == 0) begin
          paddr_mi = addr ^ 16'h4000;
          way_en   = 3'b111;
        end
        #2;
        chk("wait_rdy", pready_s, 1'b0);
        chk("wait_psel", psel_v, onehot);
        @(negedge clk);
      end
      set_ready(onehot);
    end
    #2;
    got = sb.pop_front();
    chk("done_rdy", pready_s, 1'b1);
    chk("done_psel", psel_v, got.sel);
    chk("done_pen", pen_v, got.sel);
    chk("done_rdata", prdata_s, got.rdata);

    @(negedge clk);
    psel_arb = 1'b0; penable_arb = 1'b0; set_ready(3'b000);
    #1;
    chk("back_idle", dut.state, ST_IDLE);
    chk("idle_rdy", {pready_s, prdata_s}, 33'h0);
  endtask

  initial begin
    logic [2:0] p0;
    rst_b = 1'b0; way_en = 3'b111; pwdata_mi = 32'h55; paddr_mi = 16'h0001;
    pwrite_mi = 1'b1; psel_arb = 1'b1; penable_arb = 1'b1;
    prdata_s0 = 32'h11; prdata_s1 = 32'h22; prdata_s2 = 32'h33;
    set_ready(3'b111);

    // Reset state: selects and return path quiet, broadcast still follows.
    @(posedge clk); #2;
    chk("rst_psel", psel_v, 3'b000);
    chk("rst_pen", pen_v, 3'b000);
    chk("rst_ret", {pready_s, prdata_s}, 33'h0);
    chk("rst_pclk", pclk_v, 3'b000);
    chk("rst_bc", paddr_s, 16'h0001);
    @(negedge clk);
    psel_arb = 1'b0; penable_arb = 1'b0; set_ready(3'b000);
    rst_b = 1'b1;

    // Directed transfers from the test plan.
    xfer(16'h0001, 1'b1, 3'b111, 32'h1234, 0, 1'b0);
    xfer(16'h8000, 1'b0, 3'b100, 32'h3, 1, 1'b0);
    xfer(16'h4000, 1'b0, 3'b101, 32'hdead, 0, 1'b0);
    xfer(16'hC000, 1'b0, 3'b111, 32'hbeef, 0, 1'b0);
    xfer(16'hC123, 1'b1, 3'b000, 32'hbeef, 0, 1'b0);
    xfer(16'h4010, 1'b0, 3'b010, 32'hcafe, 2, 1'b1);
    xfer(16'h0004, 1'b0, 3'b001, 32'h77, 2, 1'b1);

    // Gated clocks: only enabled slaves toggle, no change while clk high.
    @(negedge clk); way_en = 3'b010;
    @(posedge clk); #2; chk("pclk_hi", pclk_v, 3'b010);
    @(negedge clk); #1; chk("pclk_lo", pclk_v, 3'b000);
    @(posedge clk); #1; p0 = pclk_v;
    way_en = 3'b101;
    #2; chk("pclk_noglitch", pclk_v, p0);
    @(negedge clk); #1; chk("pclk_lo2", pclk_v, 3'b000);
    @(posedge clk); #2; chk("pclk_new", pclk_v, 3'b101);

    // Reset in the middle of an enable phase.
    @(negedge clk);
    way_en = 3'b111; paddr_mi = 16'h0000; psel_arb = 1'b1; penable_arb = 1'b0;
    @(negedge clk); penable_arb = 1'b1; set_ready(3'b001);
    #1; rst_b = 1'b0;
    #1;
    chk("mid_rst_psel", psel_v, 3'b000);
    chk("mid_rst_pen", pen_v, 3'b000);
    chk("mid_rst_rdy", pready_s, 1'b0);
    @(posedge clk); #2;
    chk("mid_rst_pclk", pclk_v, 3'b000);
    chk("mid_rst_st", dut.state, ST_IDLE);
    @(negedge clk);
    psel_arb = 1'b0; penable_arb = 1'b0; set_ready(3'b000);
    rst_b = 1'b1;

    // Random transfers after release.
    for (int n = 0; n < 20; n++) begin
      xfer(16'($urandom), 1'($urandom), 3'($urandom), $urandom,
           int'($urandom_range(0, 2)), 1'b0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
